// File: rtl/apb_gpio_v2_pkg.sv
// apb_gpio_v2_pkg
//   Shared definitions for the apb_gpio_v2 peripheral: register byte offsets
//   (as decoded from PADDR[6:2]), interrupt mode encodings, the debounce
//   prescaler width, and a helper that selects a pin's interrupt event.
package apb_gpio_v2_pkg;

  localparam int DBNC_DIV_W = 16;

  // Byte offsets within the 128-byte window addressed by PADDR[6:2]*4.
  localparam logic [6:0] OFF_PADDIR      = 7'h00;
  localparam logic [6:0] OFF_PADIN       = 7'h04;
  localparam logic [6:0] OFF_PADOUT      = 7'h08;
  localparam logic [6:0] OFF_OUTSET      = 7'h0C;
  localparam logic [6:0] OFF_OUTCLR      = 7'h10;
  localparam logic [6:0] OFF_INTEN       = 7'h14;
  localparam logic [6:0] OFF_INTTYPE0    = 7'h18;
  localparam logic [6:0] OFF_INTTYPE1    = 7'h1C;
  localparam logic [6:0] OFF_INTSTATUS   = 7'h20;
  localparam logic [6:0] OFF_DBNC_EN     = 7'h24;
  localparam logic [6:0] OFF_DBNC_DIV    = 7'h28;
  localparam logic [6:0] OFF_POWEREVENT  = 7'h2C;
  localparam logic [6:0] OFF_PADCFG_BASE = 7'h40;

  // Interrupt mode, indexed as {INTTYPE1[i], INTTYPE0[i]}.
  localparam logic [1:0] INT_RISE  = 2'b00;
  localparam logic [1:0] INT_FALL  = 2'b01;
  localparam logic [1:0] INT_BOTH  = 2'b10;
  localparam logic [1:0] INT_LEVEL = 2'b11;

  // Event that sets a pin's INTSTATUS bit for the given mode.
  function automatic logic int_event(input logic [1:0] mode, input logic f,
                                     input logic rise, input logic fall);
    logic hit;
    case (mode)
      INT_RISE:  hit = rise;
      INT_FALL:  hit = fall;
      INT_BOTH:  hit = rise | fall;
      INT_LEVEL: hit = f;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/apb_gpio_v2_if.sv
// apb_gpio_v2_if
//   APB bus bundle between a master and the apb_gpio_v2 slave.
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE : master -> slave
//   PRDATA/PREADY/PSLVERR            : slave  -> master
interface apb_gpio_v2_if #(
  parameter int APB_ADDR_WIDTH = 12
);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_gpio_v2_input_filter.sv
// gpio_input_filter
//   Per-pin input conditioning: 2-flop synchroniser, optional debounce filter
//   driven by a shared prescaler tick, and edge detection on the filtered value.
//   clk, rst : clock, asynchronous active-high reset
//   pin      : asynchronous pad input
//   enable   : 1 = debounce, 0 = filtered value follows the synchroniser
//   tick     : prescaler strobe, one cycle wide
//   f        : filtered value
//   rise     : f went 0->1 on the last edge
//   fall     : f went 1->0 on the last edge
module gpio_input_filter (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  input  logic enable,
  input  logic tick,
  output logic f,
  output logic rise,
  output logic fall
);

  logic       s_meta;
  logic       s;
  logic       f_q;
  logic [1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_meta <= 1'b0;
      s      <= 1'b0;
      f      <= 1'b0;
      f_q    <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
      // so s_meta -> s is a true two-stage shift.
      s_meta <= pin;
      s      <= s_meta;
      f_q    <= f;
      if (!enable) begin
        f   <= s;
        cnt <= 2'd0;
      end else if (s == f) begin
        // Any return to the filtered value restarts the stability count.
        cnt <= 2'd0;
      end else if (tick) begin
        if (cnt == 2'd2) begin
          f   <= s;
          cnt <= 2'd0;
        end else begin
          cnt <= cnt + 2'd1;
        end
      end
    end
  end

  assign rise = f & ~f_q;
  assign fall = ~f & f_q;

endmodule

// File: rtl/apb_gpio_v2.sv
// apb_gpio_v2
//   APB GPIO peripheral: direction/output/pad-config registers, atomic output
//   set/clear, per-pin debounce, and sticky W1C interrupt status.
//   HCLK, HRESET  : clock, asynchronous active-high reset
//   apb           : APB slave port (PREADY tied 1, PSLVERR on unmapped access)
//   gpio_in       : asynchronous pad inputs
//   gpio_in_sync  : filtered input values
//   gpio_out      : output register
//   gpio_dir      : direction register, 1 = output
//   gpio_padcfg   : per-pin pad configuration
//   power_event   : OR of (POWEREVENT & filtered input)
//   interrupt     : OR of INTSTATUS
module apb_gpio_v2
  import apb_gpio_v2_pkg::*;
#(
  parameter int NUM_GPIO       = 32,
  parameter int PADCFG_W       = 6,
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic                               HCLK,
  input  logic                               HRESET,
  apb_gpio_v2_if.slave                       apb,
  input  logic [NUM_GPIO-1:0]                gpio_in,
  output logic [NUM_GPIO-1:0]                gpio_in_sync,
  output logic [NUM_GPIO-1:0]                gpio_out,
  output logic [NUM_GPIO-1:0]                gpio_dir,
  output logic [NUM_GPIO-1:0][PADCFG_W-1:0]  gpio_padcfg,
  output logic                               power_event,
  output logic                               interrupt
);

  localparam int NUM_PADCFG_WORDS = (NUM_GPIO + 3) / 4;

  // ---------------------------------------------------------------- decode
  logic [4:0]          word;
  logic [6:0]          offset;
  logic                access;
  logic                wr;
  logic                padcfg_hit;
  logic [NUM_GPIO-1:0] wdata;
  logic                unused_bits;

  assign word       = apb.PADDR[6:2];
  assign offset     = {word, 2'b00};
  assign access     = apb.PSEL & apb.PENABLE;
  assign wr         = access & apb.PWRITE;
  assign wdata      = apb.PWDATA[NUM_GPIO-1:0];
  // PADCFGk lives at word 16+k, so word[3:0] is k once the offset is >= 0x40.
  assign padcfg_hit = (offset >= OFF_PADCFG_BASE) &&
                      (int'(word[3:0]) < NUM_PADCFG_WORDS);
  assign unused_bits = ^{apb.PADDR[APB_ADDR_WIDTH-1:7], apb.PADDR[1:0], apb.PWDATA};

  // ------------------------------------------------------------- registers
  logic [NUM_GPIO-1:0]               dir_q, out_q, inten_q, inttype0_q, inttype1_q;
  logic [NUM_GPIO-1:0]               intstatus_q, dbnc_en_q, powerevent_q;
  logic [DBNC_DIV_W-1:0]             dbnc_div_q, presc_q;
  logic [NUM_GPIO-1:0][PADCFG_W-1:0] padcfg_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dir_q        <= '0;
      out_q        <= '0;
      inten_q      <= '0;
      inttype0_q   <= '0;
      inttype1_q   <= '0;
      dbnc_en_q    <= '0;
      dbnc_div_q   <= '0;
      powerevent_q <= '0;
      padcfg_q     <= '0;
    end else if (wr) begin
      case (offset)
        OFF_PADDIR:     dir_q        <= wdata;
        OFF_PADOUT:     out_q        <= wdata;
        OFF_OUTSET:     out_q        <= out_q | wdata;
        OFF_OUTCLR:     out_q        <= out_q & ~wdata;
        OFF_INTEN:      inten_q      <= wdata;
        OFF_INTTYPE0:   inttype0_q   <= wdata;
        OFF_INTTYPE1:   inttype1_q   <= wdata;
        OFF_DBNC_EN:    dbnc_en_q    <= wdata;
        OFF_DBNC_DIV:   dbnc_div_q   <= apb.PWDATA[DBNC_DIV_W-1:0];
        OFF_POWEREVENT: powerevent_q <= wdata;
        default: begin
          // PADIN, INTSTATUS and unmapped offsets fall here; only PADCFG hits store.
          for (int p = 0; p < NUM_GPIO; p++) begin
            if (padcfg_hit && ((p >> 2) == int'(word[3:0]))) begin
              padcfg_q[p] <= apb.PWDATA[8*(p%4) +: PADCFG_W];
            end
          end
        end
      endcase
    end
  end

  // ------------------------------------------------------------ prescaler
  logic tick;
  assign tick = (presc_q == dbnc_div_q);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      presc_q <= '0;
    end else if ((wr && offset == OFF_DBNC_DIV) || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // ------------------------------------------------------- per-pin inputs
  logic [NUM_GPIO-1:0] filt, rise, fall, evt;

  for (genvar i = 0; i < NUM_GPIO; i++) begin : g_pin
    gpio_input_filter u_filter (
      .clk    (HCLK),
      .rst    (HRESET),
      .pin    (gpio_in[i]),
      .enable (dbnc_en_q[i]),
      .tick   (tick),
      .f      (filt[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
    assign evt[i] = int_event({inttype1_q[i], inttype0_q[i]}, filt[i], rise[i], fall[i]);
  end

  // ------------------------------------------------------------ interrupts
  logic [NUM_GPIO-1:0] w1c;
  assign w1c = (wr && offset == OFF_INTSTATUS) ? wdata : '0;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      intstatus_q <= '0;
    end else begin
      // Set term is OR-ed after the clear so a same-cycle event wins.
      intstatus_q <= (intstatus_q & ~w1c) | (inten_q & evt);
    end
  end

  // -------------------------------------------------------------- readback
  logic [31:0] rdata;
  logic        valid;

  always_comb begin
    // NOTE: defaults first so every path assigns rdata/valid and no latch forms.
    rdata = '0;
    valid = 1'b1;
    case (offset)
      OFF_PADDIR:             rdata[NUM_GPIO-1:0]   = dir_q;
      OFF_PADIN:              rdata[NUM_GPIO-1:0]   = filt;
      OFF_PADOUT:             rdata[NUM_GPIO-1:0]   = out_q;
      OFF_OUTSET, OFF_OUTCLR: rdata                 = '0;
      OFF_INTEN:              rdata[NUM_GPIO-1:0]   = inten_q;
      OFF_INTTYPE0:           rdata[NUM_GPIO-1:0]   = inttype0_q;
      OFF_INTTYPE1:           rdata[NUM_GPIO-1:0]   = inttype1_q;
      OFF_INTSTATUS:          rdata[NUM_GPIO-1:0]   = intstatus_q;
      OFF_DBNC_EN:            rdata[NUM_GPIO-1:0]   = dbnc_en_q;
      OFF_DBNC_DIV:           rdata[DBNC_DIV_W-1:0] = dbnc_div_q;
      OFF_POWEREVENT:         rdata[NUM_GPIO-1:0]   = powerevent_q;
      default: begin
        if (padcfg_hit) begin
          for (int p = 0; p < NUM_GPIO; p++) begin
            if ((p >> 2) == int'(word[3:0])) begin
              rdata[8*(p%4) +: PADCFG_W] = padcfg_q[p];
            end
          end
        end else begin
          valid = 1'b0;
        end
      end
    endcase
  end

  assign apb.PRDATA  = rdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = access & ~valid;

  // --------------------------------------------------------------- outputs
  assign gpio_in_sync = filt;
  assign gpio_out     = out_q;
  assign gpio_dir     = dir_q;
  assign gpio_padcfg  = padcfg_q;
  assign power_event  = |(powerevent_q & filt);
  assign interrupt    = |intstatus_q;

endmodule

// File: tb/tb_apb_gpio_v2.sv
// tb_apb_gpio_v2
//   Directed bench for apb_gpio_v2 built with NUM_GPIO=8, PADCFG_W=6.
module tb_apb_gpio_v2;

  logic             HCLK = 1'b0;
  logic             HRESET;
  logic [7:0]       gpio_in;
  logic [7:0]       gpio_in_sync, gpio_out, gpio_dir;
  logic [7:0][5:0]  gpio_padcfg;
  logic             power_event, interrupt;

  int errors = 0;
  int checks = 0;

  apb_gpio_v2_if #(.APB_ADDR_WIDTH(12)) apb_bus ();

  apb_gpio_v2 #(.NUM_GPIO(8), .PADCFG_W(6), .APB_ADDR_WIDTH(12)) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .apb          (apb_bus),
    .gpio_in      (gpio_in),
    .gpio_in_sync (gpio_in_sync),
    .gpio_out     (gpio_out),
    .gpio_dir     (gpio_dir),
    .gpio_padcfg  (gpio_padcfg),
    .power_event  (power_event),
    .interrupt    (interrupt)
  );

  always #5 HCLK = ~HCLK;

  logic [11:0] reset_offs [14] = '{12'h00, 12'h04, 12'h08, 12'h0C, 12'h10, 12'h14, 12'h18,
                                    12'h1C, 12'h20, 12'h24, 12'h28, 12'h2C, 12'h40, 12'h44};

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
    @(posedge HCLK); #1;
    apb_bus.PSEL = 1'b1; apb_bus.PENABLE = 1'b0; apb_bus.PWRITE = 1'b1;
    apb_bus.PADDR = addr; apb_bus.PWDATA = data;
    @(posedge HCLK); #1;
    apb_bus.PENABLE = 1'b1;
    @(posedge HCLK); #1;
    apb_bus.PSEL = 1'b0; apb_bus.PENABLE = 1'b0; apb_bus.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] addr, output logic [31:0] data, output logic err);
    @(posedge HCLK); #1;
    apb_bus.PSEL = 1'b1; apb_bus.PENABLE = 1'b0; apb_bus.PWRITE = 1'b0;
    apb_bus.PADDR = addr;
    @(posedge HCLK); #1;
    apb_bus.PENABLE = 1'b1;
    @(negedge HCLK);
    data = apb_bus.PRDATA;
    err  = apb_bus.PSLVERR;
    @(posedge HCLK); #1;
    apb_bus.PSEL = 1'b0; apb_bus.PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        e;
    HRESET = 1'b1;
    gpio_in = '0;
    apb_bus.PSEL = 1'b0; apb_bus.PENABLE = 1'b0; apb_bus.PWRITE = 1'b0;
    apb_bus.PADDR = '0; apb_bus.PWDATA = '0;
    repeat (3) @(negedge HCLK);
    checks++;
    if ({gpio_out, gpio_dir, gpio_in_sync, gpio_padcfg, power_event, interrupt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: out=%h dir=%h sync=%h padcfg=%h pe=%b irq=%b expected all 0",
               gpio_out, gpio_dir, gpio_in_sync, gpio_padcfg, power_event, interrupt);
    end
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    for (int i = 0; i < 14; i++) begin
      apb_read(reset_offs[i], d, e);
      checks++;
      if (d !== 32'h0 || e !== 1'b0) begin
        errors++;
        $display("FAIL reset_read_%h: data=%h err=%b expected 0/0", reset_offs[i], d, e);
      end
    end
  endtask

  task automatic test_register_access();
    logic [31:0] d;
    logic        e;
    apb_write(12'h08, 32'h0000_00F0);
    apb_write(12'h0C, 32'h0000_000F);
    apb_write(12'h10, 32'h0000_0030);
    checks++;
    if (gpio_out !== 8'hCF) begin
      errors++; $display("FAIL gpio_out_set_clr: got %h expected cf", gpio_out);
    end
    apb_read(12'h08, d, e);
    checks++;
    if (d !== 32'hCF || e !== 1'b0) begin
      errors++; $display("FAIL padout_read: data=%h err=%b expected cf/0", d, e);
    end
    apb_read(12'h0C, d, e);
    checks++;
    if (d !== 32'h0 || e !== 1'b0) begin
      errors++; $display("FAIL outset_read: data=%h err=%b expected 0/0", d, e);
    end
  endtask

  task automatic test_width_errors();
    logic [31:0] d;
    logic        e;
    apb_read(12'h48, d, e);
    checks++;
    if (d !== 32'h0 || e !== 1'b1) begin
      errors++; $display("FAIL padcfg2_unmapped: data=%h err=%b expected 0/1", d, e);
    end
    apb_read(12'h30, d, e);
    checks++;
    if (d !== 32'h0 || e !== 1'b1) begin
      errors++; $display("FAIL offset30_unmapped: data=%h err=%b expected 0/1", d, e);
    end
    apb_write(12'h00, 32'hFFFF_FFFF);
    apb_read(12'h00, d, e);
    checks++;
    if (d !== 32'hFF || gpio_dir !== 8'hFF) begin
      errors++; $display("FAIL paddir_width: data=%h dir=%h expected ff/ff", d, gpio_dir);
    end
    apb_write(12'h40, 32'hFFFF_FFFF);
    apb_write(12'h48, 32'hFFFF_FFFF);
    apb_read(12'h40, d, e);
    checks++;
    if (d !== 32'h3F3F_3F3F || e !== 1'b0) begin
      errors++; $display("FAIL padcfg0_width: data=%h err=%b expected 3f3f3f3f/0", d, e);
    end
    apb_read(12'h44, d, e);
    checks++;
    if (d !== 32'h0 || e !== 1'b0) begin
      errors++; $display("FAIL padcfg1_untouched: data=%h err=%b expected 0/0", d, e);
    end
    checks++;
    if (gpio_padcfg !== 48'h0000_00FF_FFFF) begin
      errors++; $display("FAIL padcfg_out: got %h expected 0000_00ff_ffff", gpio_padcfg);
    end
    apb_write(12'h04, 32'hFFFF_FFFF);
    apb_read(12'h04, d, e);
    checks++;
    if (d !== 32'h0 || e !== 1'b0) begin
      errors++; $display("FAIL padin_write_ignored: data=%h err=%b expected 0/0", d, e);
    end
  endtask

  task automatic test_rise_interrupt();
    logic [31:0] d;
    logic        e;
    apb_write(12'h18, 32'h0);
    apb_write(12'h1C, 32'h0);
    apb_write(12'h14, 32'h08);
    gpio_in[3] = 1'b1;                  // sampled at the next edge, N
    wait_cycles(2);                     // just after N+1
    checks++;
    if (gpio_in_sync[3] !== 1'b0) begin
      errors++; $display("FAIL sync_early_n1: got %b expected 0", gpio_in_sync[3]);
    end
    wait_cycles(1);                     // just after N+2
    checks++;
    if (gpio_in_sync[3] !== 1'b1 || interrupt !== 1'b0) begin
      errors++; $display("FAIL edge_n2: sync=%b irq=%b expected 1/0", gpio_in_sync[3], interrupt);
    end
    wait_cycles(1);                     // just after N+3
    checks++;
    if (interrupt !== 1'b1) begin
      errors++; $display("FAIL irq_n3: got %b expected 1", interrupt);
    end
    apb_read(12'h20, d, e);
    checks++;
    if (d !== 32'h08) begin
      errors++; $display("FAIL rise_status: got %h expected 08", d);
    end
    apb_write(12'h20, 32'h08);
    checks++;
    if (interrupt !== 1'b0) begin
      errors++; $display("FAIL rise_w1c_irq: got %b expected 0", interrupt);
    end
  endtask

  task automatic test_both_and_level();
    logic [31:0] d;
    logic        e;
    apb_write(12'h14, 32'h20);
    apb_write(12'h1C, 32'h20);
    apb_write(12'h18, 32'h00);
    gpio_in[5] = 1'b1;
    wait_cycles(5);
    apb_read(12'h20, d, e);
    checks++;
    if (d !== 32'h20) begin
      errors++; $display("FAIL both_rise: got %h expected 20", d);
    end
    apb_write(12'h20, 32'h20);
    apb_read(12'h20, d, e);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL both_clear: got %h expected 0", d);
    end
    gpio_in[5] = 1'b0;
    wait_cycles(5);
    apb_read(12'h20, d, e);
    checks++;
    if (d !== 32'h20) begin
      errors++; $display("FAIL both_fall: got %h expected 20", d);
    end
    apb_write(12'h20, 32'h20);
    apb_write(12'h18, 32'h20);          // level mode, pin low
    apb_read(12'h20, d, e);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL level_low_idle: got %h expected 0", d);
    end
    gpio_in[5] = 1'b1;
    wait_cycles(5);
    apb_write(12'h20, 32'h20);
    apb_read(12'h20, d, e);
    checks++;
    if (d !== 32'h20 || interrupt !== 1'b1) begin
      errors++; $display("FAIL level_w1c_held: status=%h irq=%b expected 20/1", d, interrupt);
    end
    gpio_in[5] = 1'b0;
    wait_cycles(5);
    apb_write(12'h20, 32'h20);
    apb_read(12'h20, d, e);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL level_w1c_low: got %h expected 0", d);
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    logic        e;
    apb_write(12'h18, 32'h0);
    apb_write(12'h1C, 32'h0);
    apb_write(12'h14, 32'h40);
    gpio_in[6] = 1'b1;
    wait_cycles(5);
    gpio_in[6] = 1'b0;
    wait_cycles(5);
    apb_read(12'h20, d, e);
    checks++;
    if (d !== 32'h40) begin
      errors++; $display("FAIL sim_pre_status: got %h expected 40", d);
    end
    // Rise lands in INTSTATUS at edge N+3; W1C access phase ends on that same edge.
    gpio_in[6] = 1'b1;                  // sampled at N
    wait_cycles(2);                     // just after N+1
    apb_bus.PSEL = 1'b1; apb_bus.PENABLE = 1'b0; apb_bus.PWRITE = 1'b1;
    apb_bus.PADDR = 12'h20; apb_bus.PWDATA = 32'h40;
    wait_cycles(1);                     // just after N+2
    apb_bus.PENABLE = 1'b1;
    wait_cycles(1);                     // just after N+3
    apb_bus.PSEL = 1'b0; apb_bus.PENABLE = 1'b0; apb_bus.PWRITE = 1'b0;
    apb_read(12'h20, d, e);
    checks++;
    if (d !== 32'h40 || interrupt !== 1'b1) begin
      errors++; $display("FAIL set_wins_over_clear: status=%h irq=%b expected 40/1", d, interrupt);
    end
    apb_write(12'h20, 32'h40);
    apb_read(12'h20, d, e);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL sim_post_clear: got %h expected 0", d);
    end
  endtask

  task automatic test_debounce();
    logic bad;
    int   n;
    apb_write(12'h24, 32'h01);
    apb_write(12'h28, 32'h03);
    bad = 1'b0;
    gpio_in[0] = 1'b1;
    for (int i = 0; i < 26; i++) begin
      wait_cycles(1);
      if (i == 5) gpio_in[0] = 1'b0;
      if (gpio_in_sync[0] !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL debounce_glitch: sync went high, expected 0 throughout");
    end
    gpio_in[0] = 1'b1;
    n = 0;
    while (gpio_in_sync[0] !== 1'b1 && n < 40) begin
      wait_cycles(1);
      n++;
    end
    checks++;
    if (n < 11 || n > 14) begin
      errors++; $display("FAIL debounce_latency: %0d edges, expected 11..14", n);
    end
  endtask

  task automatic test_power_reset();
    logic [31:0] d;
    logic        e;
    apb_write(12'h2C, 32'h01);
    checks++;
    if (power_event !== 1'b1) begin
      errors++; $display("FAIL power_event: got %b expected 1", power_event);
    end
    apb_write(12'h18, 32'h01);
    apb_write(12'h1C, 32'h01);
    apb_write(12'h14, 32'h01);
    wait_cycles(1);
    checks++;
    if (interrupt !== 1'b1) begin
      errors++; $display("FAIL level_pin0_irq: got %b expected 1", interrupt);
    end
    gpio_in[0] = 1'b0;
    wait_cycles(5);
    checks++;
    if (gpio_in_sync[0] !== 1'b1) begin
      errors++; $display("FAIL mid_debounce_hold: got %b expected 1", gpio_in_sync[0]);
    end
    #3;
    HRESET = 1'b1;
    #1;
    checks++;
    if ({gpio_out, gpio_dir, gpio_in_sync, gpio_padcfg, power_event, interrupt} !== '0) begin
      errors++;
      $display("FAIL reset_mid_debounce: out=%h dir=%h sync=%h padcfg=%h pe=%b irq=%b expected all 0",
               gpio_out, gpio_dir, gpio_in_sync, gpio_padcfg, power_event, interrupt);
    end
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    apb_read(12'h24, d, e);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL dbnc_en_after_reset: got %h expected 0", d);
    end
  endtask

  initial begin
    test_reset();
    test_register_access();
    test_width_errors();
    test_rise_interrupt();
    test_both_and_level();
    test_simultaneous();
    test_debounce();
    test_power_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_gpio_v2.md
# apb_gpio_v2

Parametrised successor GPIO peripheral on the APB peripheral bus. Provides NUM_GPIO pins with:
- direction, output and pad-configuration registers;
- atomic set/clear of the output register;
- a programmable per-pin input debounce filter;
- per-pin sticky, write-1-to-clear interrupt status with rising, falling, both-edge and level-high modes.

It sits beside the other APB slaves and drives the pad frame and the event/interrupt controller.

## Interface
- NUM_GPIO, 32: pin count, legal 1..32.
- PADCFG_W, 6: pad-config bits per pin, legal 1..8.
- APB_ADDR_WIDTH, 12: APB address width.
- HCLK  in  1  clock, all logic on the rising edge.
- HRESET  in  1  reset, asynchronous and active-high.
- PADDR  in  APB_ADDR_WIDTH  address; only PADDR[6:2] is decoded.
- PWDATA  in  32  write data.
- PWRITE, PSEL, PENABLE  in  1  APB controls.
- PRDATA  out  32  read data.
- PREADY  out  1  tied 1.
- PSLVERR  out  1  access-phase error.
- gpio_in  in  NUM_GPIO  asynchronous pad inputs.
- gpio_in_sync  out  NUM_GPIO  filtered input value.
- gpio_out  out  NUM_GPIO  output register.
- gpio_dir  out  NUM_GPIO  direction register, 1 = output.
- gpio_padcfg  out  NUM_GPIO x PADCFG_W  per-pin pad configuration.
- power_event  out  1  OR over pins of (POWEREVENT & filtered input).
- interrupt  out  1  OR over pins of INTSTATUS.

## Operation
- **Access:** an access is PSEL & PENABLE, with offset = PADDR[6:2]*4.
- **Register map:** 0x00 PADDIR, 0x04 PADIN (RO), 0x08 PADOUT, 0x0C OUTSET (WO), 0x10 OUTCLR (WO), 0x14 INTEN, 0x18 INTTYPE0, 0x1C INTTYPE1, 0x20 INTSTATUS (W1C), 0x24 DBNC_EN, 0x28 DBNC_DIV[15:0], 0x2C POWEREVENT.
- **PADCFG:** PADCFGk at 0x40+4k, k < ceil(NUM_GPIO/4). Pin 4k+j occupies bits [8j+PADCFG_W-1 : 8j].
- **Unmapped offsets:** reads of an unmapped offset, or of a PADCFG word beyond the pins, return 0, and writes to them are ignored. PSLVERR=1 for both.
- **Unused bits:** register bits at or above NUM_GPIO, or above PADCFG_W, read 0 and are not stored. Reads of the write-only registers (OUTSET, OUTCLR) return 0; writes to PADIN are ignored. Neither raises PSLVERR.
- **OUTSET / OUTCLR:** PADOUT |= PWDATA and PADOUT &= ~PWDATA respectively.
- **Synchroniser:** 2-flop synchroniser on each pin, giving s.
- **Filter, DBNC_EN bit = 0:** filtered value f <= s every cycle.
- **Filter, DBNC_EN bit = 1:**
  - A shared prescaler counts 0..DBNC_DIV and emits `tick` in the cycle it equals DBNC_DIV, then reloads 0.
  - Per-pin 2-bit counter c: if s == f then c <= 0.
  - Else, on tick: if c == 2 then f <= s and c <= 0, else c <= c+1.
  - A change therefore needs 3 consecutive ticks of stability.
- **Edge detection:** f_q <= f; rise = f & ~f_q, fall = ~f & f_q.
- **Interrupt modes, {INTTYPE1, INTTYPE0}:** 00 rise, 01 fall, 10 rise|fall, 11 level (f == 1).
- **INTSTATUS:**
  - A bit is set when its event occurs and INTEN bit = 1; it is sticky.
  - Writing 1 clears the bit. Reads have no side effect.
  - A set and a clear of the same bit in the same cycle resolve to set.
  - In level mode the bit re-sets every cycle while f == 1 and INTEN = 1.
- **INTEN = 0:** clearing an INTEN bit does not clear a pending status bit.

## Timing
- **Reset values:** all registers, synchronisers, filters, counters and outputs are 0 during and after reset. PREADY is always 1.
- **PRDATA and PSLVERR:** combinational from PADDR and register state; PRDATA is valid whenever PSEL=1.
- **Write effect:** visible from the cycle after the access-phase edge.
- **gpio_in path, debounce off:**
  - Sampled at edge N; f updates at edge N+2.
  - INTSTATUS and interrupt rise at edge N+3.
- **Debounce on:** f updates on the tick edge completing the third stable tick.
- **Filter bypass toggle:** changing DBNC_EN takes effect next cycle. Clearing a pin's bit zeroes its c.
- **DBNC_DIV write:** reloads the prescaler to 0.
- **Reset mid-debounce:** discards progress.
- **Glitch rejection:** a glitch shorter than one tick period, with s returning to f, restarts c at 0.

## Structure
- **Package apb_gpio_v2_pkg:**
  - register offset localparams;
  - INTTYPE encoding localparams;
  - DBNC_DIV width (16).
- **Sub-module gpio_input_filter:** one per pin. Contains the synchroniser, filter counter, f and f_q. Inputs: pin, enable, tick. Outputs: f, rise, fall.
- **Top level:** the prescaler, APB decode, registers and interrupt logic.

## Test plan
- **Reset and register access:** reset, read all offsets → PRDATA=0. Write PADOUT=0x0000_00F0, OUTSET=0x0F, OUTCLR=0x30 → gpio_out=0xCF.
- **Rising-edge interrupt:** INTTYPE=00, INTEN bit 3, debounce off. Drive gpio_in[3] 0→1 at edge N → interrupt=1 after edge N+3 and INTSTATUS=0x8. Write INTSTATUS=0x8 → interrupt=0 next cycle.
- **Both-edge and level modes:**
  - Pin 5 in mode 10: toggle it twice → status set after each edge.
  - Pin 5 in mode 11, held high: W1C leaves the bit set. Drive low, then W1C → clears.
- **Debounce:** DBNC_EN bit 0, DBNC_DIV=3. Pulse gpio_in[0] high for 6 cycles → no change to gpio_in_sync[0]. Hold it high → gpio_in_sync[0]=1 on the third stable tick, within 12 cycles of s changing.
- **Error and width handling:** NUM_GPIO=8 build. Read 0x48 → PSLVERR=1, PRDATA=0. Write PADDIR=0xFFFF_FFFF → reads 0xFF. PADCFG0 write 0xFFFF_FFFF → reads 0x3F3F_3F3F.
- **Reset and simultaneous events:** HRESET asserted mid-debounce → all outputs 0 immediately. An event on a bit in the same cycle as W1C of that bit → bit remains 1.
